// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : Instruction-decode stage of a five-stage MIPS pipeline. Owns the
//             32x32 register file (written by write-back, read here with a
//             same-cycle write bypass), decodes the supported opcode subset
//             and registers everything into the ID/EX pipeline register.
//  Ports    : clock, reset             - clock / synchronous active-high reset
//             id_pc_4, id_instruction  - fetched PC+4 and instruction word
//             id_flush                 - loads a bubble into ID/EX
//             wb_regWrite/writeReg/writeData - register-file write port
//             ex_*                     - registered ID/EX outputs
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_pc_4,
  input  logic [31:0] id_instruction,
  input  logic        id_flush,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_writeReg,
  input  logic [31:0] wb_writeData,
  output logic [31:0] ex_pc_4,
  output logic [31:0] ex_branchPc,
  output logic [31:0] ex_rsData,
  output logic [31:0] ex_rtData,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_writeReg,
  output logic [2:0]  ex_aluOp,
  output logic        ex_aluSrc,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_memToReg,
  output logic        ex_branch,
  output logic        ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_ext;

  assign op      = id_instruction[31:26];
  assign rs_idx  = id_instruction[25:21];
  assign rt_idx  = id_instruction[20:16];
  assign rd_idx  = id_instruction[15:11];
  assign funct   = id_instruction[5:0];
  assign imm_ext = {{16{id_instruction[15]}}, id_instruction[15:0]};

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [31:0] regs_q [32];
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_regWrite && (wb_writeReg != 5'd0)) begin
      regs_q[wb_writeReg] <= wb_writeData;
    end
  end

  // A nonzero index matching wb_writeReg implies the write is not to $0,
  // so the bypass never leaks a value into $0 reads.
  always_comb begin
    if (rs_idx == 5'd0)
      rs_data = 32'd0;
    else if (wb_regWrite && (wb_writeReg == rs_idx))
      rs_data = wb_writeData;
    else
      rs_data = regs_q[rs_idx];

    if (rt_idx == 5'd0)
      rt_data = 32'd0;
    else if (wb_regWrite && (wb_writeReg == rt_idx))
      rt_data = wb_writeData;
    else
      rt_data = regs_q[rt_idx];
  end

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [2:0] dec_aluOp;
  logic [4:0] dec_writeReg;
  logic       dec_aluSrc;
  logic       dec_regWrite;
  logic       dec_memRead;
  logic       dec_memWrite;
  logic       dec_memToReg;
  logic       dec_branch;
  logic       dec_illegal;

  always_comb begin
    dec_aluOp    = ALU_ADD;
    dec_writeReg = 5'd0;
    dec_aluSrc   = 1'b0;
    dec_regWrite = 1'b0;
    dec_memRead  = 1'b0;
    dec_memWrite = 1'b0;
    dec_memToReg = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;

    case (op)
      OP_RTYPE: begin
        // The all-zero word is the canonical nop: no control, not illegal.
        if (id_instruction != 32'd0) begin
          dec_regWrite = 1'b1;
          dec_writeReg = rd_idx;
          case (funct)
            FN_ADD:  dec_aluOp = ALU_ADD;
            FN_SUB:  dec_aluOp = ALU_SUB;
            FN_AND:  dec_aluOp = ALU_AND;
            FN_OR:   dec_aluOp = ALU_OR;
            FN_SLT:  dec_aluOp = ALU_SLT;
            default: begin
              dec_regWrite = 1'b0;
              dec_writeReg = 5'd0;
              dec_illegal  = 1'b1;
            end
          endcase
        end
      end
      OP_ADDI: begin
        dec_regWrite = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_writeReg = rt_idx;
      end
      OP_LW: begin
        dec_regWrite = 1'b1;
        dec_memRead  = 1'b1;
        dec_memToReg = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_writeReg = rt_idx;
      end
      OP_SW: begin
        dec_memWrite = 1'b1;
        dec_aluSrc   = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_aluOp  = ALU_SUB;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  logic [31:0] pc4_q, branchPc_q, rsData_q, rtData_q, imm_q;
  logic [4:0]  rt_q, writeReg_q;
  logic [2:0]  aluOp_q;
  logic        aluSrc_q, regWrite_q, memRead_q, memWrite_q, memToReg_q;
  logic        branch_q, illegal_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc4_q      <= 32'd0;
      branchPc_q <= 32'd0;
      rsData_q   <= 32'd0;
      rtData_q   <= 32'd0;
      imm_q      <= 32'd0;
      rt_q       <= 5'd0;
      writeReg_q <= 5'd0;
      aluOp_q    <= 3'd0;
      aluSrc_q   <= 1'b0;
      regWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memToReg_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      // Data fields load even on a flush; only control is squashed.
      pc4_q      <= id_pc_4;
      branchPc_q <= id_pc_4 + {imm_ext[29:0], 2'b00};
      rsData_q   <= rs_data;
      rtData_q   <= rt_data;
      imm_q      <= imm_ext;
      rt_q       <= rt_idx;
      if (id_flush) begin
        writeReg_q <= 5'd0;
        aluOp_q    <= 3'd0;
        aluSrc_q   <= 1'b0;
        regWrite_q <= 1'b0;
        memRead_q  <= 1'b0;
        memWrite_q <= 1'b0;
        memToReg_q <= 1'b0;
        branch_q   <= 1'b0;
        illegal_q  <= 1'b0;
      end else begin
        writeReg_q <= dec_writeReg;
        aluOp_q    <= dec_aluOp;
        aluSrc_q   <= dec_aluSrc;
        regWrite_q <= dec_regWrite;
        memRead_q  <= dec_memRead;
        memWrite_q <= dec_memWrite;
        memToReg_q <= dec_memToReg;
        branch_q   <= dec_branch;
        illegal_q  <= dec_illegal;
      end
    end
  end

  assign ex_pc_4     = pc4_q;
  assign ex_branchPc = branchPc_q;
  assign ex_rsData   = rsData_q;
  assign ex_rtData   = rtData_q;
  assign ex_imm      = imm_q;
  assign ex_rt       = rt_q;
  assign ex_writeReg = writeReg_q;
  assign ex_aluOp    = aluOp_q;
  assign ex_aluSrc   = aluSrc_q;
  assign ex_regWrite = regWrite_q;
  assign ex_memRead  = memRead_q;
  assign ex_memWrite = memWrite_q;
  assign ex_memToReg = memToReg_q;
  assign ex_branch   = branch_q;
  assign ex_illegal  = illegal_q;

endmodule
`default_nettype wire
